// File: rtl/phase_pkg.sv
// Shared phase-table definitions: entry field layout, dump sync byte, dump FSM encoding.
package phase_pkg;

  // Phase table entry fields (also used by the controller's table editor)
  localparam int unsigned GREENMAN_BIT = 26;
  localparam int unsigned SEC_HI       = 25;
  localparam int unsigned SEC_LO       = 20;
  localparam int unsigned LIGHTB_HI    = 19;
  localparam int unsigned LIGHTB_LO    = 10;
  localparam int unsigned LIGHTA_HI    = 9;
  localparam int unsigned LIGHTA_LO    = 0;

  typedef struct packed {
    logic       greenman;
    logic [5:0] seconds;
    logic [9:0] light_b;
    logic [9:0] light_a;
  } phase_entry_t;

  // First byte of every dump frame
  localparam logic [7:0] DUMP_SYNC = 8'hA5;

  // Dump FSM encoding
  localparam int unsigned STATE_W = 4;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_HDR  = 4'd1;
  localparam logic [3:0] ST_IDX  = 4'd2;
  localparam logic [3:0] ST_D3   = 4'd3;
  localparam logic [3:0] ST_D2   = 4'd4;
  localparam logic [3:0] ST_D1   = 4'd5;
  localparam logic [3:0] ST_D0   = 4'd6;
  localparam logic [3:0] ST_CSUM = 4'd7;
  localparam logic [3:0] ST_FIN  = 4'd8;

  // Select byte 'sel' (3 = MSB) of a 32-bit word
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; ready is high while idle and low from load until one clock past the stop bit.
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic             active_q, active_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             txd_q, txd_d;

  // Next-state: load frames the byte, each baud tick shifts out the next bit
  always_comb begin
    active_d   = active_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
    if (!active_q) begin
      if (load) begin
        active_d   = 1'b1;
        shift_d    = {1'b1, data};
        txd_d      = 1'b0;
        baud_cnt_d = '0;
        bit_cnt_d  = 4'd0;
      end
    end else if (baud_cnt_q == CNT_W'(BAUD_DIV - 1)) begin
      baud_cnt_d = '0;
      if (bit_cnt_q == 4'd9) begin
        active_d = 1'b0;
        txd_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        txd_d     = shift_q[0];
        shift_d   = {1'b1, shift_q[8:1]};
      end
    end else begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  // State register; reset forces the line idle-high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '1;
      txd_q      <= 1'b1;
    end else begin
      active_q   <= active_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

  assign ready = ~active_q;
  assign txd   = txd_q;

endmodule

// File: rtl/phase_table_dump.sv
// Streams phase table entries 0..N over UART: sync byte, {index, 4 data bytes} per entry, XOR checksum.
module phase_table_dump
  import phase_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ENTRY_W  = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  entry_count,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [ENTRY_W-1:0] rd_data,
  output logic               txd,
  output logic               busy,
  output logic               done
);

  // One extra bit so the last index (2^ADDR_W-1) terminates without wrapping
  localparam int unsigned IDX_W = ADDR_W + 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  n_q, n_d;
  logic [7:0]         csum_q, csum_d;
  logic [31:0]        hold_q, hold_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               fetch1_q, fetch1_d;
  logic               fetch2_q, fetch2_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               uart_ready;
  logic               load_c;
  logic [7:0]         tx_byte_c;

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_c),
    .data  (tx_byte_c),
    .ready (uart_ready),
    .txd   (txd)
  );

  // Sequencing: each byte state hands its byte to the sender when it is ready, then advances
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    csum_d    = csum_q;
    rd_addr_d = rd_addr_q;
    fetch1_d  = 1'b0;
    fetch2_d  = fetch1_q;
    hold_d    = fetch2_q ? 32'(rd_data) : hold_q;
    done_d    = 1'b0;
    load_c    = 1'b0;
    tx_byte_c = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          n_d     = entry_count;
          csum_d  = 8'h00;
          idx_d   = '0;
        end
      end
      ST_HDR: begin
        tx_byte_c = DUMP_SYNC;
        if (uart_ready) begin
          load_c    = 1'b1;
          rd_addr_d = '0;
          fetch1_d  = 1'b1;
          state_d   = ST_IDX;
        end
      end
      ST_IDX: begin
        tx_byte_c = 8'(idx_q);
        if (uart_ready) begin
          load_c  = 1'b1;
          csum_d  = csum_q ^ tx_byte_c;
          state_d = ST_D3;
        end
      end
      ST_D3: begin
        tx_byte_c = byte_of(hold_q, 2'd3);
        if (uart_ready) begin
          load_c  = 1'b1;
          csum_d  = csum_q ^ tx_byte_c;
          state_d = ST_D2;
        end
      end
      ST_D2: begin
        tx_byte_c = byte_of(hold_q, 2'd2);
        if (uart_ready) begin
          load_c  = 1'b1;
          csum_d  = csum_q ^ tx_byte_c;
          state_d = ST_D1;
        end
      end
      ST_D1: begin
        tx_byte_c = byte_of(hold_q, 2'd1);
        if (uart_ready) begin
          load_c  = 1'b1;
          csum_d  = csum_q ^ tx_byte_c;
          state_d = ST_D0;
        end
      end
      ST_D0: begin
        tx_byte_c = byte_of(hold_q, 2'd0);
        if (uart_ready) begin
          load_c = 1'b1;
          csum_d = csum_q ^ tx_byte_c;
          if (idx_q == IDX_W'(n_q)) begin
            state_d = ST_CSUM;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            rd_addr_d = ADDR_W'(idx_q + IDX_W'(1));
            fetch1_d  = 1'b1;
            state_d   = ST_IDX;
          end
        end
      end
      ST_CSUM: begin
        tx_byte_c = csum_q;
        if (uart_ready) begin
          load_c  = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        if (uart_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      csum_q    <= 8'h00;
      hold_q    <= 32'h0;
      rd_addr_q <= '0;
      fetch1_q  <= 1'b0;
      fetch2_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      csum_q    <= csum_d;
      hold_q    <= hold_d;
      rd_addr_q <= rd_addr_d;
      fetch1_q  <= fetch1_d;
      fetch2_q  <= fetch2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_phase_table_dump.sv
// Directed bench for phase_table_dump: UART decode of the frame, checked against hand values and a byte model.
module tb_phase_table_dump;

  localparam int B1 = 4;
  localparam int B2 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start2;
  logic [3:0]  cnt1, cnt2;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [26:0] rd_data1, rd_data2;
  logic        txd1, txd2, busy1, busy2, done1, done2;

  always #5 clk = ~clk;

  phase_table_dump #(.BAUD_DIV(B1), .ADDR_W(4), .ENTRY_W(27)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .entry_count(cnt1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .txd(txd1), .busy(busy1), .done(done1));

  phase_table_dump #(.BAUD_DIV(B2), .ADDR_W(4), .ENTRY_W(27)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .entry_count(cnt2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .txd(txd2), .busy(busy2), .done(done2));

  // Synchronous-read table model for dut1
  logic [26:0] tbl1 [16];
  always @(posedge clk) rd_data1 <= tbl1[rd_addr1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART receivers
  logic [7:0] rxq1[$], rxq2[$];
  int         rxt1[$], rxt2[$];
  int         ferr[2];
  logic [7:0] expq[$];

  function automatic logic cur_txd(input int sel);
    return (sel == 0) ? txd1 : txd2;
  endfunction

  task automatic rx_run(input int sel, input int b);
    logic [7:0] d;
    logic       v, bv;
    bit         abort;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cur_txd(sel) === 1'b0) begin
        t0 = cyc; abort = 0; d = 8'h00; bv = 1'b0;
        for (int bi = 0; bi < 10 && !abort; bi++) begin
          for (int s = 0; s < b && !abort; s++) begin
            if (!(bi == 0 && s == 0)) @(negedge clk);
            if (rst_n !== 1'b1) abort = 1;
            else begin
              v = cur_txd(sel);
              if (s == 0) bv = v;
              else if (v !== bv) ferr[sel]++;
            end
          end
          if (!abort) begin
            if (bi == 0 && bv !== 1'b0) ferr[sel]++;
            if (bi == 9 && bv !== 1'b1) ferr[sel]++;
            if (bi >= 1 && bi <= 8) d[bi-1] = bv;
          end
        end
        if (!abort) begin
          if (sel == 0) begin rxq1.push_back(d); rxt1.push_back(t0); end
          else begin rxq2.push_back(d); rxt2.push_back(t0); end
        end
      end
    end
  endtask

  initial rx_run(0, B1);
  initial rx_run(1, B2);

  // Reference frame built from the table contents
  function automatic void build_exp(input int n);
    logic [31:0] w;
    logic [7:0]  cs;
    expq.delete();
    expq.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i <= n; i++) begin
      w = 32'(tbl1[i]);
      expq.push_back(8'(i)); cs ^= 8'(i);
      for (int k = 3; k >= 0; k--) begin
        expq.push_back(w[k*8 +: 8]);
        cs ^= w[k*8 +: 8];
      end
    end
    expq.push_back(cs);
  endfunction

  function automatic int period_errors1();
    int bad = 0;
    for (int i = 1; i < rxt1.size(); i++)
      if (rxt1[i] - rxt1[i-1] != 10*B1 + 1) bad++;
    return bad;
  endfunction

  // Full dump on dut1 with frame, timing, handshake and address-sweep checks
  task automatic run_dump1(input int n, input int exp_bytes, input logic [7:0] exp_csum,
                           input bit disturb, input string tag);
    int guard, dc, mask, busy_gap, fe0, bad;
    rxq1.delete(); rxt1.delete();
    fe0 = ferr[0];
    build_exp(n);
    @(negedge clk); cnt1 = 4'(n); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    guard = 0; dc = 0; mask = 0; busy_gap = 0;
    while (guard < 20000) begin
      @(negedge clk); guard++;
      mask = mask | (1 << int'(rd_addr1));
      if (done1 === 1'b1) begin dc++; break; end
      if (busy1 !== 1'b1) busy_gap++;
      if (disturb && guard == 100) begin start1 = 1'b1; cnt1 = ~4'(n); end
      if (disturb && guard == 101) start1 = 1'b0;
    end
    repeat (6) begin
      @(negedge clk);
      if (done1 === 1'b1) dc++;
    end
    check({tag, "_done_pulses"}, 32'(dc), 32'd1);
    check({tag, "_busy_after"}, 32'(busy1), 32'd0);
    check({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
    check({tag, "_byte_count"}, 32'(rxq1.size()), 32'(exp_bytes));
    check({tag, "_addr_sweep"}, 32'(mask), 32'((1 << (n + 1)) - 1));
    check({tag, "_frame_err"}, 32'(ferr[0] - fe0), 32'd0);
    check({tag, "_byte_period"}, 32'(period_errors1()), 32'd0);
    if (rxq1.size() > 0) begin
      check({tag, "_header"}, 32'(rxq1[0]), 32'hA5);
      check({tag, "_csum"}, 32'(rxq1[rxq1.size()-1]), 32'(exp_csum));
    end else begin
      check({tag, "_no_bytes"}, 32'(rxq1.size()), 32'(exp_bytes));
    end
    bad = 0;
    for (int i = 0; i < expq.size(); i++)
      if (i >= rxq1.size() || rxq1[i] !== expq[i]) bad++;
    check({tag, "_stream_vs_model"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int          n;
    logic [26:0] base;
    logic [26:0] step;
    int          exp_bytes;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t vecs[4];

  task automatic load_table(input logic [26:0] base, input logic [26:0] step);
    for (int i = 0; i < 16; i++) tbl1[i] = base + 27'(i) * step;
  endtask

  initial begin
    int guard, dc;
    logic [7:0] exp2 [7];
    int fe1, bad;

    vecs[0] = '{0,  27'h4F2CCB2, 27'h0,      7,  8'h88};
    vecs[1] = '{15, 27'h0,       27'h111111, 82, 8'h00};
    vecs[2] = '{2,  27'h5,       27'h100,    17, 8'h05};
    vecs[3] = '{0,  27'h7FFFFFF, 27'h0,      7,  8'hF8};

    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; cnt1 = 4'h0; cnt2 = 4'h0;
    rd_data2 = 27'h0;
    load_table(27'h0, 27'h0);
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd1), 32'd1);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_done", 32'(done1), 32'd0);
    check("reset_rd_addr", 32'(rd_addr1), 32'd0);
    check("reset_txd2", 32'(txd2), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      load_table(vecs[v].base, vecs[v].step);
      run_dump1(vecs[v].n, vecs[v].exp_bytes, vecs[v].exp_csum, 1'b0, $sformatf("vec%0d", v));
    end

    // Start latency: busy on the accepting edge, start bit one edge later
    rxq1.delete(); rxt1.delete();
    @(negedge clk); cnt1 = 4'h0; start1 = 1'b1;
    @(posedge clk); #1;
    check("start_busy_edge_k", 32'(busy1), 32'd1);
    check("start_txd_edge_k", 32'(txd1), 32'd1);
    start1 = 1'b0;
    @(posedge clk); #1;
    check("start_txd_edge_k1", 32'(txd1), 32'd0);
    guard = 0; dc = 0;
    while (guard < 2000 && dc == 0) begin
      @(negedge clk); guard++;
      if (done1 === 1'b1) dc++;
    end
    repeat (3) @(negedge clk);
    check("start_seq_done", 32'(dc), 32'd1);
    check("start_seq_bytes", 32'(rxq1.size()), 32'd7);

    // Re-pulsed start and entry_count change mid-dump must not alter the frame
    load_table(vecs[2].base, vecs[2].step);
    run_dump1(2, 17, 8'h05, 1'b1, "disturb");

    // Reset during the third data byte, then a clean frame
    load_table(vecs[0].base, vecs[0].step);
    rxq1.delete(); rxt1.delete();
    @(negedge clk); cnt1 = 4'h0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    guard = 0;
    while (guard < 2000 && rxq1.size() < 4) begin @(negedge clk); guard++; end
    while (guard < 2000 && txd1 !== 1'b0) begin @(negedge clk); guard++; end
    check("rst_mid_reached", 32'(guard < 2000), 32'd1);
    check("rst_mid_txd_low_before", 32'(txd1), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_txd_high", 32'(txd1), 32'd1);
    check("rst_mid_busy", 32'(busy1), 32'd0);
    dc = 0;
    repeat (3) begin @(negedge clk); if (done1 === 1'b1) dc++; end
    rst_n = 1'b1;
    repeat (60) begin @(negedge clk); if (done1 === 1'b1) dc++; end
    check("rst_mid_no_done", 32'(dc), 32'd0);
    check("rst_mid_idle_busy", 32'(busy1), 32'd0);
    run_dump1(0, 7, 8'h88, 1'b0, "after_rst");

    // BAUD_DIV=2: source data rewritten one cycle after capture
    exp2 = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
    rxq2.delete(); rxt2.delete();
    fe1 = ferr[1];
    rd_data2 = 27'h1234567;
    @(negedge clk); cnt2 = 4'h0; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rd_data2 = 27'h7654321;
    guard = 0; dc = 0;
    while (guard < 2000 && dc == 0) begin
      @(negedge clk); guard++;
      if (done2 === 1'b1) dc++;
    end
    repeat (3) @(negedge clk);
    check("b2_done", 32'(dc), 32'd1);
    check("b2_bytes", 32'(rxq2.size()), 32'd7);
    check("b2_frame_err", 32'(ferr[1] - fe1), 32'd0);
    bad = 0;
    for (int i = 0; i < 7; i++)
      if (i >= rxq2.size() || rxq2[i] !== exp2[i]) bad++;
    check("b2_captured_entry", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 1; i < rxt2.size(); i++)
      if (rxt2[i] - rxt2[i-1] != 10*B2 + 1) bad++;
    check("b2_byte_period", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
